// File: rtl/alu_share_arbiter.sv
// Shares one 16-bit combinational ALU between the EX stage (port 0) and the branch unit (port 1).
// Round-robin grant in IDLE, operands registered into the ALU, result and flags registered back to the owner.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [2:0]  req_op_0,
    input  logic [15:0] req_a_0,
    input  logic [15:0] req_b_0,
    input  logic        req_cin_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [2:0]  req_op_1,
    input  logic [15:0] req_a_1,
    input  logic [15:0] req_b_1,
    input  logic        req_cin_1,
    output logic        rsp_valid_0,
    input  logic        rsp_ready_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_1,
    output logic [15:0] rsp_z,
    output logic [4:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [2:0]  alu_op,
    output logic        alu_cin,
    input  logic [15:0] alu_z,
    input  logic        alu_c_out,
    input  logic        alu_overflow,
    input  logic        alu_lt,
    input  logic        alu_eq,
    input  logic        alu_gt,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid_k && req_ready_k;
    // a response transfers on a rising edge where rsp_valid_k && rsp_ready_k.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_prio;
    logic        r_owner;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_cin;
    logic        r_err;
    logic [15:0] r_z;
    logic [4:0]  r_flags;
    logic        r_rsp_err;

    logic        w_grant;
    logic        w_accept;
    logic        w_owner_rsp_ready;
    logic [2:0]  w_sel_op;
    logic        w_sel_err;

    assign w_grant  = (req_valid_0 && req_valid_1) ? r_prio : req_valid_1;
    assign w_sel_op = w_grant ? req_op_1 : req_op_0;
    assign w_sel_err = (w_sel_op == 3'b100) || (w_sel_op == 3'b101) || (w_sel_op == 3'b110);
    assign w_owner_rsp_ready = r_owner ? rsp_ready_1 : rsp_ready_0;

    always_comb begin
        w_next_state = r_state;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        rsp_valid_0  = 1'b0;
        rsp_valid_1  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst_n so ready reads 0 for the whole reset window
                req_ready_0 = rst_n && !w_grant && req_valid_0;
                req_ready_1 = rst_n && w_grant && req_valid_1;
                w_accept    = req_ready_0 || req_ready_1;
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid_0 = !r_owner;
                rsp_valid_1 = r_owner;
                if (w_owner_rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == RESP && w_owner_rsp_ready) begin
                r_prio <= ~r_owner;
            end
        end
    end

    // Operand registers only load on accept, so the ALU inputs are stable through EXEC and RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b0;
            r_op    <= 3'b000;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_cin   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_grant;
            r_op    <= w_sel_op;
            r_a     <= w_grant ? req_a_1 : req_a_0;
            r_b     <= w_grant ? req_b_1 : req_b_0;
            r_cin   <= w_grant ? req_cin_1 : req_cin_0;
            r_err   <= w_sel_err;
        end
    end

    // Illegal opcodes return zero with carry/overflow suppressed; compare flags pass through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z       <= 16'h0000;
            r_flags   <= 5'b00000;
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_z       <= r_err ? 16'h0000 : alu_z;
            r_flags   <= {alu_c_out && !r_err, alu_overflow && !r_err, alu_lt, alu_eq, alu_gt};
            r_rsp_err <= r_err;
        end
    end

    assign alu_in1     = r_a;
    assign alu_in2     = r_b;
    assign alu_op      = r_op;
    assign alu_cin     = r_cin;
    assign rsp_z       = r_z;
    assign rsp_flags   = r_flags;
    assign rsp_err     = r_rsp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model and an expected-response queue.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_valid_0, req_ready_0, req_cin_0;
    logic [2:0]  req_op_0;
    logic [15:0] req_a_0, req_b_0;
    logic        req_valid_1, req_ready_1, req_cin_1;
    logic [2:0]  req_op_1;
    logic [15:0] req_a_1, req_b_1;
    logic        rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
    logic [15:0] rsp_z;
    logic [4:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] alu_in1, alu_in2;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_z;
    logic        alu_c_out, alu_overflow, alu_lt, alu_eq, alu_gt;
    logic [1:0]  dbg_state;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_cin_0(req_cin_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_cin_1(req_cin_1),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_z(rsp_z), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_z(alu_z), .alu_c_out(alu_c_out), .alu_overflow(alu_overflow),
        .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- ALU stub: returns {z, c_out, overflow, lt, eq, gt} ----------------
    // Carry/overflow on ADD/SUB are unsigned carry/borrow; illegal ops return junk so suppression is visible.
    function automatic logic [20:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        logic [16:0] wide;
        logic [15:0] z;
        logic        c, ovf, lt, eq, gt;
        lt = $signed(a) < $signed(b);
        eq = (a == b);
        gt = $signed(a) > $signed(b);
        c = 1'b0;
        ovf = 1'b0;
        case (op)
            3'b000: z = a & b;
            3'b001: z = a | b;
            3'b010: begin wide = {1'b0, a} + {1'b0, b} + {16'h0, cin}; z = wide[15:0]; c = wide[16]; ovf = c; end
            3'b011: begin wide = {1'b0, a} - {1'b0, b}; z = wide[15:0]; c = wide[16]; ovf = c; end
            3'b111: z = {15'h0, lt};
            default: begin z = a ^ b ^ 16'hA5A5; c = 1'b1; ovf = 1'b1; end
        endcase
        return {z, c, ovf, lt, eq, gt};
    endfunction

    always_comb {alu_z, alu_c_out, alu_overflow, alu_lt, alu_eq, alu_gt} = alu_model(alu_op, alu_in1, alu_in2, alu_cin);

    // Expected response packed as {err, flags[4:0], z[15:0]}
    function automatic logic [21:0] expect_rsp(input logic [2:0] op, input logic [15:0] a,
                                               input logic [15:0] b, input logic cin);
        logic [20:0] r;
        r = alu_model(op, a, b, cin);
        if (op == 3'd4 || op == 3'd5 || op == 3'd6) return {1'b1, 2'b00, r[2:0], 16'h0000};
        return {1'b0, r[4:0], r[20:5]};
    endfunction

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [21:0] exp_q[$];
    int          grant_log[$];
    int          grant_cyc[$];
    int          cyc = 0;
    bit          m_busy, m_owner, m_prio, m_acc0, m_acc1, auto_drop;
    int          m_age;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b;
    logic        m_cin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_owner = 0; m_prio = 0; m_age = 0;
        m_acc0 = 0; m_acc1 = 0;
        m_op = 3'b000; m_a = 16'h0; m_b = 16'h0; m_cin = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req_valid_0 = 0; req_op_0 = 0; req_a_0 = 0; req_b_0 = 0; req_cin_0 = 0;
        req_valid_1 = 0; req_op_1 = 0; req_a_1 = 0; req_b_1 = 0; req_cin_1 = 0;
        rsp_ready_0 = 0; rsp_ready_1 = 0;
    endtask

    task automatic send(input int k, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
        if (k == 0) begin
            req_valid_0 = 1; req_op_0 = op; req_a_0 = a; req_b_0 = b; req_cin_0 = cin;
        end else begin
            req_valid_1 = 1; req_op_1 = op; req_a_1 = a; req_b_1 = b; req_cin_1 = cin;
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // One clock: check outputs against the model mid-low-phase, clock, then advance the model.
    task automatic step();
        bit g, er0, er1, ev0, ev1, own_rdy;
        #1;
        g = 0; er0 = 0; er1 = 0;
        if (!m_busy) begin
            g = (req_valid_0 && req_valid_1) ? m_prio : req_valid_1;
            er0 = req_valid_0 && !g;
            er1 = req_valid_1 && g;
        end
        ev0 = m_busy && m_age >= 1 && !m_owner;
        ev1 = m_busy && m_age >= 1 && m_owner;
        check("req_ready_0", 32'(req_ready_0), 32'(er0));
        check("req_ready_1", 32'(req_ready_1), 32'(er1));
        check("rsp_valid_0", 32'(rsp_valid_0), 32'(ev0));
        check("rsp_valid_1", 32'(rsp_valid_1), 32'(ev1));
        if ((ev0 || ev1) && exp_q.size() > 0)
            check("rsp_payload", 32'({rsp_err, rsp_flags, rsp_z}), 32'(exp_q[0]));
        check("alu_operands", {alu_in1, alu_in2}, {m_a, m_b});
        check("alu_ctl", 32'({alu_cin, alu_op}), 32'({m_cin, m_op}));
        if (req_ready_0) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
        else if (req_ready_1) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
        own_rdy = m_owner ? rsp_ready_1 : rsp_ready_0;
        @(posedge clk);
        cyc++;
        if (!m_busy) begin
            if (er0 || er1) begin
                m_busy = 1; m_age = 0; m_owner = g;
                m_op  = g ? req_op_1  : req_op_0;
                m_a   = g ? req_a_1   : req_a_0;
                m_b   = g ? req_b_1   : req_b_0;
                m_cin = g ? req_cin_1 : req_cin_0;
                exp_q.push_back(expect_rsp(m_op, m_a, m_b, m_cin));
                if (g) m_acc1 = 1; else m_acc0 = 1;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (own_rdy) begin
            m_busy = 0;
            m_prio = ~m_owner;
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        if (auto_drop && m_acc0) begin req_valid_0 = 0; m_acc0 = 0; end
        if (auto_drop && m_acc1) begin req_valid_1 = 0; m_acc1 = 0; end
    endtask

    task automatic drain();
        int n;
        rsp_ready_0 = 1; rsp_ready_1 = 1; auto_drop = 1;
        n = 0;
        while ((m_busy || req_valid_0 || req_valid_1) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check("drain_timeout", 32'(n), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0;
        auto_drop = 1;
        drive_idle();
        model_clear();
        @(negedge clk);
        do_reset();

        // reset values
        check("rst_rsp_z", 32'(rsp_z), 32'h0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        step();

        // single ADD on port 0
        rsp_ready_0 = 1;
        send(0, 3'b010, 16'd4, 16'd3, 1'b0);
        step();
        step();
        check("add_valid", 32'(rsp_valid_0), 32'h1);
        check("add_z", 32'(rsp_z), 32'd7);
        check("add_flags", 32'(rsp_flags), 32'b00001);
        check("add_err", 32'(rsp_err), 32'h0);
        step();

        // SUB with borrow on port 1, then prio returns to port 0
        rsp_ready_1 = 1;
        send(1, 3'b011, 16'd3, 16'd4, 1'b0);
        step();
        step();
        check("sub_z", 32'(rsp_z), 32'hFFFF);
        check("sub_flags", 32'(rsp_flags), 32'b11100);
        step();
        send(0, 3'b000, 16'h1111, 16'h0101, 1'b0);
        send(1, 3'b001, 16'h1111, 16'h0101, 1'b0);
        #1;
        check("sub_prio_r0", 32'(req_ready_0), 32'h1);
        check("sub_prio_r1", 32'(req_ready_1), 32'h0);
        drain();

        // contention from reset: both continuously valid
        do_reset();
        auto_drop = 0;
        grant_log.delete();
        grant_cyc.delete();
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        send(0, 3'b000, 16'hF0F0, 16'h0FF0, 1'b0);
        send(1, 3'b111, 16'd3, 16'd4, 1'b0);
        repeat (12) begin
            step();
            if (rsp_valid_0) check("cont_z0", 32'(rsp_z), 32'h00F0);
            if (rsp_valid_1) check("cont_z1", 32'(rsp_z), 32'h0001);
        end
        check("cont_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("cont_order", 32'(grant_log[i]), 32'(i % 2));
            if (i > 0) check("cont_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
        end
        auto_drop = 1;
        req_valid_0 = 0; req_valid_1 = 0;
        m_acc0 = 0; m_acc1 = 0;
        drain();

        // illegal opcode
        rsp_ready_0 = 1;
        send(0, 3'b101, 16'd5, 16'd5, 1'b0);
        step();
        step();
        check("ill_z", 32'(rsp_z), 32'h0);
        check("ill_err", 32'(rsp_err), 32'h1);
        check("ill_flags", 32'(rsp_flags), 32'b00010);
        step();

        // backpressure on port 0 while port 1 waits
        rsp_ready_0 = 0; rsp_ready_1 = 1;
        send(0, 3'b010, 16'd100, 16'd23, 1'b0);
        step();
        send(1, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0);
        step();
        repeat (5) begin
            step();
            check("bp_valid0", 32'(rsp_valid_0), 32'h1);
            check("bp_z", 32'(rsp_z), 32'd123);
            check("bp_ready1", 32'(req_ready_1), 32'h0);
        end
        rsp_ready_0 = 1;
        step();
        #1;
        check("bp_accept1", 32'(req_ready_1), 32'h1);
        drain();

        // reset in EXEC
        rsp_ready_0 = 1;
        send(0, 3'b010, 16'h1234, 16'h0001, 1'b0);
        step();
        rst_n = 0;
        #1;
        check("mid_rst_in1", 32'(alu_in1), 32'h0);
        check("mid_rst_ctl", 32'({alu_cin, alu_op, alu_in2}), 32'h0);
        check("mid_rst_rsp", 32'({rsp_err, rsp_flags, rsp_z}), 32'h0);
        check("mid_rst_valid", 32'({rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1}), 32'h0);
        drive_idle();
        model_clear();
        @(negedge clk);
        rst_n = 1;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        repeat (3) step();
        send(0, 3'b001, 16'h00FF, 16'hFF00, 1'b0);
        send(1, 3'b000, 16'h00FF, 16'hFF00, 1'b0);
        #1;
        check("post_rst_r0", 32'(req_ready_0), 32'h1);
        check("post_rst_r1", 32'(req_ready_1), 32'h0);
        drain();

        // randomized traffic
        auto_drop = 1;
        repeat (3000) begin
            if (!req_valid_0 && $urandom_range(0, 2) == 0)
                send(0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
            if (!req_valid_1 && $urandom_range(0, 2) == 0)
                send(1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
            rsp_ready_0 = ($urandom_range(0, 3) != 0);
            rsp_ready_1 = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
